spker_tone_gen: RTL and testbench

- Speaker tone generator: the consumer of the 11-bit divider preset (TONE) driven by the note decoder.
- Turns the preset into a square wave on the speaker pin with a loadable up-counter and a toggle flip-flop.
- Sits between the note decoder and the speaker pin.
- New presets are accepted only at a counter-overflow boundary, so note changes never produce a glitch. The rest code (all-ones) gives silence.

---
 rtl/tone_pkg.sv | 13 +
 rtl/tone_cnt.sv | 46 ++++
 rtl/spker_tone_gen.sv | 95 +++++++++
 tb/tb_spker_tone_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared tone width, rest code and note presets
package tone_pkg;

  localparam int TONE_W = 11;

  // All-ones preset: rest/silence, also the counter overflow value
  localparam logic [TONE_W-1:0] TONE_REST = 11'h7FF;

  // Note presets shared with the note decoder
  localparam logic [TONE_W-1:0] TONE_L1 = 11'h305;
  localparam logic [TONE_W-1:0] TONE_H1 = 11'h582;

endpackage

// File: rtl/tone_cnt.sv
// rtl/tone_cnt.sv - loadable up-counter with sync clear and terminal-count flag
module tone_cnt
  import tone_pkg::*;
#(
  parameter int                WIDTH     = TONE_W,
  parameter logic [WIDTH-1:0]  REST_CODE = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear parks at the rest code, load wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = REST_CODE;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register; reset parks it so the first enabled edge reloads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= REST_CODE;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == REST_CODE);

endmodule

// File: rtl/spker_tone_gen.sv
// rtl/spker_tone_gen.sv - glitch-free speaker square wave from a divider preset
module spker_tone_gen
  import tone_pkg::*;
#(
  parameter int                WIDTH     = TONE_W,
  parameter logic [WIDTH-1:0]  REST_CODE = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] TONE,
  input  logic             EN,
  output logic             SPKS,
  output logic             FULL,
  output logic             MUTE,
  output logic             CHG
);

  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             reload;

  logic [WIDTH-1:0] tl_q, tl_d;
  logic             spks_q, spks_d;
  logic             full_q, full_d;
  logic             mute_q, mute_d;
  logic             chg_q, chg_d;

  // TONE is only accepted at overflow, so a note change never cuts a half-period short
  assign reload = EN && tc;

  tone_cnt #(
    .WIDTH     (WIDTH),
    .REST_CODE (REST_CODE)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .clr_i      (!EN),
    .load_i     (reload),
    .load_val_i (TONE),
    .cnt_o      (cnt),
    .tc_o       (tc)
  );

  // Next state of latch, toggle and pulse outputs
  always_comb begin
    tl_d   = tl_q;
    spks_d = spks_q;
    mute_d = mute_q;
    full_d = 1'b0;
    chg_d  = 1'b0;
    if (!EN) begin
      tl_d   = REST_CODE;
      spks_d = 1'b0;
      mute_d = 1'b1;
    end else if (reload) begin
      tl_d  = TONE;
      chg_d = (TONE != tl_q);
      if (TONE == REST_CODE) begin
        // Entering or staying in rest forces silence rather than toggling
        spks_d = 1'b0;
        mute_d = 1'b1;
      end else begin
        spks_d = ~spks_q;
        mute_d = 1'b0;
        full_d = 1'b1;
      end
    end
  end

  // Output and latched-tone registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tl_q   <= REST_CODE;
      spks_q <= 1'b0;
      full_q <= 1'b0;
      mute_q <= 1'b1;
      chg_q  <= 1'b0;
    end else begin
      tl_q   <= tl_d;
      spks_q <= spks_d;
      full_q <= full_d;
      mute_q <= mute_d;
      chg_q  <= chg_d;
    end
  end

  assign SPKS = spks_q;
  assign FULL = full_q;
  assign MUTE = mute_q;
  assign CHG  = chg_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_spker_tone_gen.sv
// tb/tb_spker_tone_gen.sv - self-checking bench for spker_tone_gen
module tb_spker_tone_gen;

  logic        CLK;
  logic        RST_N;
  logic [10:0] TONE;
  logic        EN;
  logic        SPKS, FULL, MUTE, CHG;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        en;
    logic [10:0] tone;
    logic        spks;
    logic        full;
    logic        mute;
    logic        chg;
    logic        park;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  spker_tone_gen dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .TONE  (TONE),
    .EN    (EN),
    .SPKS  (SPKS),
    .FULL  (FULL),
    .MUTE  (MUTE),
    .CHG   (CHG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int half(input logic [10:0] t);
    return 2048 - int'(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one vector, queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    vec_t e;
    EN   = v.en;
    TONE = v.tone;
    exp_q.push_back(v);
    tick();
    e = exp_q.pop_front();
    chk({e.name, ".spks"}, int'(SPKS), int'(e.spks));
    chk({e.name, ".full"}, int'(FULL), int'(e.full));
    chk({e.name, ".mute"}, int'(MUTE), int'(e.mute));
    chk({e.name, ".chg"},  int'(CHG),  int'(e.chg));
    if (e.park) chk({e.name, ".cnt"}, int'(dut.u_cnt.cnt_q), 32'h7FF);
  endtask

  // Cycles until the next FULL pulse; 0 if it never comes
  task automatic wait_full(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (FULL) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic add(input string nm, input logic en, input logic [10:0] t,
                     input logic s, input logic f, input logic m, input logic c,
                     input logic p);
    vec_t v;
    v.name = nm; v.en = en; v.tone = t;
    v.spks = s; v.full = f; v.mute = m; v.chg = c; v.park = p;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    int fulls;

    // Per-cycle table: boundary preset, rest entry/exit, enable drop
    add("park",      1'b0, 11'h7FE, 0, 0, 1, 0, 1);
    add("min_ld0",   1'b1, 11'h7FE, 1, 1, 0, 1, 0);
    add("min_inc0",  1'b1, 11'h7FE, 1, 0, 0, 0, 0);
    add("min_ld1",   1'b1, 11'h7FE, 0, 1, 0, 0, 0);
    add("min_inc1",  1'b1, 11'h7FE, 0, 0, 0, 0, 0);
    add("min_ld2",   1'b1, 11'h7FE, 1, 1, 0, 0, 0);
    add("pre_rest",  1'b1, 11'h7FF, 1, 0, 0, 0, 0);
    add("rest_ent",  1'b1, 11'h7FF, 0, 0, 1, 1, 0);
    add("rest_1",    1'b1, 11'h7FF, 0, 0, 1, 0, 0);
    add("rest_2",    1'b1, 11'h7FF, 0, 0, 1, 0, 0);
    add("rest_exit", 1'b1, 11'h40C, 1, 1, 0, 1, 0);
    add("tone_inc",  1'b1, 11'h40C, 1, 0, 0, 0, 0);
    add("en_drop",   1'b0, 11'h40C, 0, 0, 1, 0, 1);
    add("en_rise",   1'b1, 11'h305, 1, 1, 0, 1, 0);

    // Asynchronous reset with enable high, before any clock edge
    RST_N = 1'b1; EN = 1'b1; TONE = 11'h305;
    #1 RST_N = 1'b0;
    #1;
    chk("rst.spks", int'(SPKS), 0);
    chk("rst.mute", int'(MUTE), 1);
    chk("rst.full", int'(FULL), 0);
    chk("rst.chg",  int'(CHG),  0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Steady tone 0x305
    tick();
    chk("first.spks", int'(SPKS), 1);
    chk("first.chg",  int'(CHG),  1);
    chk("first.full", int'(FULL), 1);
    chk("first.mute", int'(MUTE), 0);
    wait_full(4000, n);
    chk("steady.half0", n, half(11'h305));
    chk("steady.spks0", int'(SPKS), 0);
    chk("steady.chg0",  int'(CHG),  0);
    wait_full(4000, n);
    chk("steady.half1", n, half(11'h305));
    chk("steady.spks1", int'(SPKS), 1);

    // Asynchronous reset mid-count while SPKS is high
    repeat (300) tick();
    RST_N = 1'b0;
    #1;
    chk("midrst.spks", int'(SPKS), 0);
    chk("midrst.mute", int'(MUTE), 1);
    chk("midrst.full", int'(FULL), 0);
    chk("midrst.chg",  int'(CHG),  0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();
    chk("restart.spks", int'(SPKS), 1);
    chk("restart.full", int'(FULL), 1);
    wait_full(4000, n);
    chk("restart.half", n, half(11'h305));

    // Glitch-free change 500 cycles into a half-period
    repeat (500) tick();
    TONE = 11'h582;
    wait_full(4000, n);
    chk("change.remain", n, half(11'h305) - 500);
    chk("change.chg",    int'(CHG), 1);
    wait_full(4000, n);
    chk("change.half",   n, half(11'h582));
    chk("change.chg_off", int'(CHG), 0);

    // Table-driven per-cycle section
    foreach (vecs[i]) apply(vecs[i]);

    // Re-enabled tone keeps steady timing
    wait_full(4000, n);
    chk("reen.half", n, half(11'h305));

    // Rest entry mid-period waits for the reload
    repeat (100) tick();
    TONE = 11'h7FF;
    n = 0;
    for (int i = 1; i <= 4000; i++) begin
      tick();
      if (MUTE) begin
        n = i;
        break;
      end
    end
    chk("rest.delay", n, half(11'h305) - 100);
    chk("rest.spks",  int'(SPKS), 0);
    chk("rest.chg",   int'(CHG),  1);
    fulls = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (FULL || !MUTE || SPKS) fulls++;
    end
    chk("rest.silent", fulls, 0);

    // Rest exit to 0x40C
    TONE = 11'h40C;
    tick();
    chk("exit.spks", int'(SPKS), 1);
    chk("exit.chg",  int'(CHG),  1);
    wait_full(4000, n);
    chk("exit.half0", n, half(11'h40C));
    wait_full(4000, n);
    chk("exit.half1", n, half(11'h40C));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
